// File: rtl/register_file_pkg.sv
// Shared constants for the register file: default geometry and the x0 index.
package register_file_pkg;
  localparam int DEF_WIDTH      = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_NUM_REGS   = 2 ** DEF_ADDR_WIDTH;
  localparam int ZERO_REG       = 0;
endpackage

// File: rtl/register_file_read_port.sv
// One asynchronous read port: register mux, x0 forcing, optional write-first
// forwarding selected by the REGFILE_BYPASS_EN macro.
module register_file_read_port
  import register_file_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_REGS   = 2 ** ADDR_WIDTH
) (
  input  logic                           rst,
  input  logic [NUM_REGS-1:0][WIDTH-1:0] regs,
  input  logic [ADDR_WIDTH-1:0]          addr,
  input  logic                           wr_en,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [WIDTH-1:0]               wr_data,
  output logic [WIDTH-1:0]               rd_data
);
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  localparam logic [ADDR_WIDTH-1:0] X0 = ADDR_WIDTH'(ZERO_REG);

  always_comb begin
    rd_data = regs[addr];
    if (BYPASS && wr_en && (wr_addr != X0) && (wr_addr == addr)) rd_data = wr_data;
    // x0 and reset override everything, including forwarding
    if (rst || (addr == X0)) rd_data = '0;
  end
endmodule

// File: rtl/register_file.sv
// 2-read/1-write register file with hardwired-zero x0 and async reset.
// Build option: define REGFILE_BYPASS_EN for write-first read forwarding.
module register_file
  import register_file_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] Rs1,
  input  logic [ADDR_WIDTH-1:0] Rs2,
  input  logic [ADDR_WIDTH-1:0] Rd,
  input  logic [WIDTH-1:0]      WriteData,
  output logic [WIDTH-1:0]      ReadData1,
  output logic [WIDTH-1:0]      ReadData2
);
  localparam int NUM_REGS  = 2 ** ADDR_WIDTH;
  localparam int NUM_PORTS = 2;
  localparam logic [ADDR_WIDTH-1:0] X0 = ADDR_WIDTH'(ZERO_REG);

  logic [NUM_REGS-1:0][WIDTH-1:0]       regs;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_PORTS-1:0][WIDTH-1:0]      rd_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         regs     <= '0;
    else if (RegWrite && (Rd != X0)) regs[Rd] <= WriteData;
  end

  assign rd_addr = {Rs2, Rs1};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rp
    register_file_read_port #(
      .WIDTH     (WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .NUM_REGS  (NUM_REGS)
    ) u_rp (
      .rst    (rst),
      .regs   (regs),
      .addr   (rd_addr[p]),
      .wr_en  (RegWrite),
      .wr_addr(Rd),
      .wr_data(WriteData),
      .rd_data(rd_data[p])
    );
  end

  assign ReadData1 = rd_data[0];
  assign ReadData2 = rd_data[1];
endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file; array model of architectural state.
module tb_register_file;
  localparam int W  = 32;
  localparam int AW = 5;
  localparam int N  = 32;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          RegWrite = 1'b0;
  logic [AW-1:0] Rs1 = '0, Rs2 = '0, Rd = '0;
  logic [W-1:0]  WriteData = '0;
  logic [W-1:0]  ReadData1, ReadData2;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] model [N];

  register_file #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .RegWrite(RegWrite), .Rs1(Rs1), .Rs2(Rs2), .Rd(Rd),
    .WriteData(WriteData), .ReadData1(ReadData1), .ReadData2(ReadData2)
  );

  always #5 clk = ~clk;

  // Architectural read value given the current write-port inputs.
  function automatic logic [W-1:0] exp_rd(input int a);
    if (rst || a == 0) return '0;
    if (BYP && RegWrite && Rd != 0 && int'(Rd) == a) return WriteData;
    return model[a];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < N; i++) model[i] = '0;
  endtask

  // Drive one write cycle; inputs change at negedge, model updates after posedge.
  task automatic do_write(input int rd, input logic [W-1:0] d, input logic we);
    @(negedge clk);
    RegWrite = we; Rd = AW'(rd); WriteData = d;
    @(posedge clk); #1;
    if (we && rd != 0 && !rst) model[rd] = d;
    RegWrite = 1'b0;
  endtask

  task automatic test_reset();
    clear_model();
    Rs1 = 5; Rs2 = 31; #1;
    checks++;
    if (ReadData1 !== 0 || ReadData2 !== 0) begin
      errors++; $display("FAIL reset_state rd1=%h rd2=%h required 0", ReadData1, ReadData2);
    end
    @(negedge clk); rst = 1'b0;
    do_write(9, 32'h0BAD_F00D, 1'b1);
    Rs1 = 9; #1;
    checks++;
    if (ReadData1 !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL first_write_after_reset got=%h required=%h", ReadData1, 32'h0BAD_F00D);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < N; i++) do_write(i, W'(i * 4 + 100), 1'b1);
    for (int i = 0; i < N - 1; i++) begin
      Rs1 = AW'(i); Rs2 = AW'(i + 1); #1;
      checks++;
      if (ReadData1 !== ((i == 0) ? W'(0) : W'(i * 4 + 100)) || ReadData1 !== exp_rd(i)) begin
        errors++; $display("FAIL fill_rd1[%0d] got=%h required=%h", i, ReadData1, exp_rd(i));
      end
      checks++;
      if (ReadData2 !== W'((i + 1) * 4 + 100)) begin
        errors++; $display("FAIL fill_rd2[%0d] got=%h required=%h", i + 1, ReadData2, W'((i + 1) * 4 + 100));
      end
    end
  endtask

  task automatic test_x0();
    do_write(0, 32'hDEAD_BEEF, 1'b1);
    Rs1 = 0; Rs2 = 0; #1;
    checks++;
    if (ReadData1 !== 0 || ReadData2 !== 0) begin
      errors++; $display("FAIL x0_write rd1=%h rd2=%h required 0", ReadData1, ReadData2);
    end
    // x0 must also read zero while a write to x0 is being presented
    @(negedge clk); RegWrite = 1'b1; Rd = 0; WriteData = 32'hFFFF_FFFF; #1;
    checks++;
    if (ReadData1 !== 0) begin
      errors++; $display("FAIL x0_during_write got=%h required 0", ReadData1);
    end
    @(posedge clk); #1; RegWrite = 1'b0;
  endtask

  task automatic test_disabled();
    Rs1 = 5; #1;
    checks++;
    if (ReadData1 !== W'(120)) begin
      errors++; $display("FAIL disabled_pre got=%h required=%h", ReadData1, W'(120));
    end
    do_write(5, 32'h1234_5678, 1'b0);
    Rs1 = 5; #1;
    checks++;
    if (ReadData1 !== W'(120)) begin
      errors++; $display("FAIL disabled_write got=%h required=%h", ReadData1, W'(120));
    end
  endtask

  task automatic test_reset_clear();
    int bad;
    @(negedge clk); #2;
    rst = 1'b1; clear_model();
    RegWrite = 1'b1; Rd = 4; WriteData = 32'h5555_5555;
    repeat (3) @(posedge clk);
    #2; RegWrite = 1'b0; rst = 1'b0;
    bad = 0;
    for (int i = 0; i < N; i++) begin
      Rs1 = AW'(i); #1;
      if (ReadData1 !== 0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL reset_clear nonzero_regs=%0d required 0", bad);
    end
  endtask

  task automatic test_reset_priority();
    do_write(7, 32'h0000_0011, 1'b1);
    // asynchronous clear between edges, released before any edge
    @(negedge clk); #1; rst = 1'b1; #1; rst = 1'b0; clear_model();
    Rs1 = 7; #1;
    checks++;
    if (ReadData1 !== 0) begin
      errors++; $display("FAIL async_clear r7=%h required 0", ReadData1);
    end
    do_write(7, 32'h0000_0022, 1'b1);
    @(negedge clk);
    RegWrite = 1'b1; Rd = 7; WriteData = 32'hA5A5_A5A5;
    #2; rst = 1'b1; clear_model();
    @(posedge clk); #2;
    RegWrite = 1'b0; rst = 1'b0;
    Rs1 = 7; #1;
    checks++;
    if (ReadData1 !== 0) begin
      errors++; $display("FAIL reset_priority r7=%h required 0", ReadData1);
    end
  endtask

  task automatic test_bypass();
    logic [W-1:0] pre;
    do_write(3, W'(112), 1'b1);
    do_write(8, W'(132), 1'b1);
    @(negedge clk);
    Rs1 = 3; Rs2 = 8; RegWrite = 1'b1; Rd = 3; WriteData = 32'hCAFE_F00D; #1;
    pre = BYP ? 32'hCAFE_F00D : W'(112);
    checks++;
    if (ReadData1 !== pre) begin
      errors++; $display("FAIL bypass_pre got=%h required=%h", ReadData1, pre);
    end
    checks++;
    if (ReadData2 !== W'(132)) begin
      errors++; $display("FAIL bypass_other_port got=%h required=%h", ReadData2, W'(132));
    end
    @(posedge clk); #1; model[3] = 32'hCAFE_F00D; RegWrite = 1'b0; #1;
    checks++;
    if (ReadData1 !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL bypass_post got=%h required=%h", ReadData1, 32'hCAFE_F00D);
    end
  endtask

  task automatic test_random();
    int bad1, bad2;
    bad1 = 0; bad2 = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      RegWrite  = 1'($urandom_range(0, 1));
      Rd        = AW'($urandom_range(0, N - 1));
      WriteData = W'($urandom);
      Rs1       = (n % 5 == 0) ? Rd : AW'($urandom_range(0, N - 1));
      Rs2       = (n % 7 == 0) ? Rs1 : AW'($urandom_range(0, N - 1));
      #1;
      if (ReadData1 !== exp_rd(int'(Rs1))) bad1++;
      if (ReadData2 !== exp_rd(int'(Rs2))) bad2++;
      @(posedge clk); #1;
      if (RegWrite && Rd != 0) model[Rd] = WriteData;
    end
    RegWrite = 1'b0;
    checks++;
    if (bad1 != 0) begin
      errors++; $display("FAIL random_rd1 mismatched_cycles=%0d required 0", bad1);
    end
    checks++;
    if (bad2 != 0) begin
      errors++; $display("FAIL random_rd2 mismatched_cycles=%0d required 0", bad2);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_x0();
    test_disabled();
    test_reset_clear();
    test_reset_priority();
    test_bypass();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, data width of every register and data port.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 5, register address width; register count NUM_REGS = 2**ADDR_WIDTH (32 by default).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port RegWrite, input, 1 bit: write enable, sampled at the rising edge of clk.
REQ-006 The block SHALL have port Rs1, input, ADDR_WIDTH bits: read address, port 1.
REQ-007 The block SHALL have port Rs2, input, ADDR_WIDTH bits: read address, port 2.
REQ-008 The block SHALL have port Rd, input, ADDR_WIDTH bits: write address.
REQ-009 The block SHALL have port WriteData, input, WIDTH bits: write data.
REQ-010 The block SHALL have port ReadData1, output, WIDTH bits: contents of register Rs1.
REQ-011 The block SHALL have port ReadData2, output, WIDTH bits: contents of register Rs2.

Function
REQ-012 The block SHALL hold NUM_REGS registers of WIDTH bits; register 0 (x0) reads as zero at all times.
REQ-013 Writes SHALL be synchronous: on a rising edge of clk with rst=0, RegWrite=1 and Rd!=0, register Rd SHALL take the value of WriteData; zero write latency, so the new value is visible on the read ports immediately after that edge.
REQ-014 A write SHALL NOT occur when RegWrite=0 or Rd=0; a write to x0 is silently discarded with no error indication.
REQ-015 Reads SHALL be combinational and asynchronous: ReadData1/ReadData2 follow Rs1/Rs2 and register contents with no clock latency.
REQ-016 The two read ports SHALL be independent; Rs1=Rs2 (including both 0) is legal and returns the same value on both ports.
REQ-017 Reading register 0 SHALL return all zeros on either port regardless of any write attempt or bypass setting.
REQ-018 When a read address equals Rd during a write cycle, the read value SHALL follow REQ-024/REQ-025.

Reset
REQ-019 Assertion of rst SHALL immediately (asynchronously) clear every register to 0, independent of clk.
REQ-020 While rst=1, writes SHALL be ignored and both read ports SHALL output 0.
REQ-021 Reset asserted mid-operation, including in the same cycle as a write, SHALL take priority; the write is lost.
REQ-022 After rst deasserts, the first rising edge of clk SHALL accept writes normally.

Configuration
REQ-023 The block SHALL use the macro REGFILE_BYPASS_EN to select write-to-read forwarding.
REQ-024 With REGFILE_BYPASS_EN defined: if RegWrite=1, Rd!=0, rst=0 and Rsx=Rd, ReadDatax SHALL equal WriteData combinationally in the same cycle (write-first behaviour).
REQ-025 Without REGFILE_BYPASS_EN: ReadDatax SHALL return the stored (old) value until the write edge, then the new value.

Structure
REQ-026 A shared package SHALL define the default WIDTH (32), the default ADDR_WIDTH (5), a derived NUM_REGS constant, and the x0 index constant ZERO_REG=0.
REQ-027 Read-port logic (address decode/mux, x0 forcing, optional bypass) SHALL live in one sub-module, register_file_read_port, instantiated twice.

Verification
REQ-028 The bench SHALL cover a fill-and-readback scenario: reset, then write i*4+100 to Rd=i for i=0..31 with RegWrite=1, then read Rs1=i, Rs2=i+1 for i=0..30.
- Expected: ReadData1 = i*4+100 for i>=1 and 0 for i=0; ReadData2 = (i+1)*4+100.
REQ-029 The bench SHALL cover a write to x0: Rd=0, WriteData=32'hDEADBEEF, RegWrite=1, then Rs1=Rs2=0 -> both ReadData1 and ReadData2 = 32'h0.
REQ-030 The bench SHALL cover a disabled write: with r5=120, drive RegWrite=0, Rd=5, WriteData=32'h12345678 for one edge -> ReadData1 at Rs1=5 remains 120.
REQ-031 The bench SHALL cover reset clearing: after the fill scenario, assert rst for 3 cycles without a clock edge dependency -> reading Rs1=0..31 returns 0 on every register.
REQ-032 The bench SHALL cover reset priority: assert rst asynchronously mid-cycle while RegWrite=1, Rd=7, WriteData=32'hA5A5A5A5 -> r7 reads 0 after reset.
REQ-033 The bench SHALL cover bypass: with r3=112, write Rd=3, WriteData=32'hCAFEF00D with Rs1=3 before the edge.
- With REGFILE_BYPASS_EN defined: ReadData1 = 32'hCAFEF00D before the edge.
- Without REGFILE_BYPASS_EN: ReadData1 = 112 before the edge and 32'hCAFEF00D after it.
